machine_ctl: RTL

- Eight-phase instruction sequencer for the 8-bit RISC core. Sits directly upstream of the ALU.
- Fetches each two-byte instruction and latches the opcode.
- Generates the strobes that drive the ALU (alu_ena), accumulator, PC, instruction register and data-bus driver.
- Executes HLT/SKZ/ADD/ANDD/XORR/LDA/STO/JMP (opcodes 000..111).

---
 rtl/machine_ctl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/machine_ctl.sv
// Eight-phase instruction sequencer for the 8-bit RISC core: fetch, opcode latch, and ALU/acc/PC/IR/bus strobes.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN (otherwise instr_cnt is tied to 0).
module machine_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       opcode,
  input  logic             zero,
  output logic             load_ir,
  output logic             rd,
  output logic             wr,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             alu_ena,
  output logic             load_acc,
  output logic             datactl_ena,
  output logic             halt,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7;

  localparam logic [2:0] OP_HLT  = 3'b000, OP_SKZ  = 3'b001, OP_ADD = 3'b010, OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100, OP_LDA  = 3'b101, OP_STO = 3'b110, OP_JMP  = 3'b111;

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       zero_q, zero_d;
  logic       halted_q, halted_d;
  logic       run;

  assign run = ena & ~halted_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    zero_d   = zero_q;
    halted_d = halted_q;
    if (run) begin
      // HLT parks the sequencer in S3 instead of advancing
      if (state_q == S3 && op_q == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        state_d = state_q + 3'd1;
      end
      if (state_q == S2) begin
        op_d   = opcode;
        zero_d = zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S0;
      op_q     <= OP_HLT;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      zero_q   <= zero_d;
      halted_q <= halted_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (run && state_q == S7) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

  logic is_alu;
  logic s_load_ir, s_rd, s_wr, s_inc_pc, s_load_pc, s_alu_ena, s_load_acc, s_datactl;
  logic gate;

  assign is_alu = (op_q == OP_ADD) || (op_q == OP_ANDD) || (op_q == OP_XORR) || (op_q == OP_LDA);

  always_comb begin
    s_load_ir  = 1'b0;
    s_rd       = 1'b0;
    s_wr       = 1'b0;
    s_inc_pc   = 1'b0;
    s_load_pc  = 1'b0;
    s_alu_ena  = 1'b0;
    s_load_acc = 1'b0;
    s_datactl  = 1'b0;
    unique case (state_q)
      S0: begin
        s_rd      = 1'b1;
        s_load_ir = 1'b1;
      end
      S1: begin
        s_rd      = 1'b1;
        s_load_ir = 1'b1;
        s_inc_pc  = 1'b1;
      end
      S2: ;
      S3: s_inc_pc = (op_q != OP_HLT);
      S4: begin
        s_rd      = is_alu;
        s_inc_pc  = (op_q == OP_SKZ) && zero_q;
        s_load_pc = (op_q == OP_JMP);
        s_datactl = (op_q == OP_STO);
      end
      S5: begin
        s_rd      = is_alu;
        s_alu_ena = is_alu;
        s_inc_pc  = (op_q == OP_SKZ) && zero_q;
        s_load_pc = (op_q == OP_JMP);
        s_datactl = (op_q == OP_STO);
        s_wr      = (op_q == OP_STO);
      end
      S6: begin
        s_rd       = is_alu;
        s_load_acc = is_alu;
        s_datactl  = (op_q == OP_STO);
      end
      S7: ;
      default: ;
    endcase
  end

  // Strobes are suppressed while frozen, halted or in reset
  assign gate        = ena & rst_n & ~halted_q;
  assign load_ir     = s_load_ir  & gate;
  assign rd          = s_rd       & gate;
  assign wr          = s_wr       & gate;
  assign inc_pc      = s_inc_pc   & gate;
  assign load_pc     = s_load_pc  & gate;
  assign alu_ena     = s_alu_ena  & gate;
  assign load_acc    = s_load_acc & gate;
  assign datactl_ena = s_datactl  & gate;
  assign halt        = halted_q & rst_n;
  assign state       = state_q;

endmodule
